// File: rtl/core_branch_bp_if.sv
// core_branch_bp_if: fetch-lookup, execute-resolve and redirect signals of the
// branch resolver / predictor, bundled so fetch, execute and the resolver share one port.
`timescale 1ns/1ps
interface core_branch_bp_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] f_pc;
    logic            f_pred_taken;
    logic [XLEN-1:0] f_pred_target;
    logic            x_valid;
    logic            x_is_branch;
    logic            x_is_jump;
    logic [2:0]      x_cond;
    logic [XLEN-1:0] x_rs1;
    logic [XLEN-1:0] x_rs2;
    logic [XLEN-1:0] x_pc;
    logic [XLEN-1:0] x_target;
    logic            x_pred_taken;
    logic [XLEN-1:0] x_pred_target;
    logic            pc_load;
    logic [XLEN-1:0] pc_new;
    logic            flush;
    logic            init_busy;
    logic [31:0]     stat_resolved;
    logic [31:0]     stat_mispredict;

    modport master (
        output f_pc, x_valid, x_is_branch, x_is_jump, x_cond, x_rs1, x_rs2,
               x_pc, x_target, x_pred_taken, x_pred_target,
        input  f_pred_taken, f_pred_target, pc_load, pc_new, flush,
               init_busy, stat_resolved, stat_mispredict
    );

    modport slave (
        input  f_pc, x_valid, x_is_branch, x_is_jump, x_cond, x_rs1, x_rs2,
               x_pc, x_target, x_pred_taken, x_pred_target,
        output f_pred_taken, f_pred_target, pc_load, pc_new, flush,
               init_busy, stat_resolved, stat_mispredict
    );
endinterface

// File: rtl/core_branch_bp.sv
// core_branch_bp: execute-stage branch resolver with a direct-mapped BTB and
// 2-bit bimodal counters. Redirects fetch only on a mispredict and trains the
// table on the clock edge that ends the resolving cycle.
// Optional statistics counters are enabled with the macro CORE_BRANCH_STATS_EN.
`timescale 1ns/1ps
module core_branch_bp #(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 16,
    parameter int IDX_LSB = 2
) (
    input  logic          clk,
    input  logic          rst,
    core_branch_bp_if.slave bp
);
    localparam int IW = $clog2(ENTRIES);
    localparam int TW = XLEN - IDX_LSB - IW;

    typedef enum logic {INIT, RUN} state_t;

    state_t          state_q;
    logic [IW-1:0]   ptr_q;
    logic            valid_q  [ENTRIES];
    logic [TW-1:0]   tag_q    [ENTRIES];
    logic [XLEN-1:0] target_q [ENTRIES];
    logic [1:0]      ctr_q    [ENTRIES];

    logic [IW-1:0]   fIdx;
    logic [TW-1:0]   fTag;
    logic [IW-1:0]   xIdx;
    logic [TW-1:0]   xTag;
    logic            xHit;
    logic            satisfied;
    logic            cf;
    logic            taken;
    logic            mispredict;
    logic            unusedBits;

    assign fIdx = bp.f_pc[IDX_LSB +: IW];
    assign fTag = bp.f_pc[XLEN-1 -: TW];
    assign xIdx = bp.x_pc[IDX_LSB +: IW];
    assign xTag = bp.x_pc[XLEN-1 -: TW];
    assign xHit = valid_q[xIdx] && (tag_q[xIdx] == xTag);
    assign unusedBits = ^bp.f_pc[IDX_LSB-1:0];

    // Clear sequencer: rst always restarts the sweep from entry 0, then hand over to RUN
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= INIT;
            ptr_q   <= '0;
        end else begin
            case (state_q)
                INIT: begin
                    ptr_q <= ptr_q + 1'b1;
                    if (ptr_q == {IW{1'b1}}) begin
                        state_q <= RUN;
                    end
                end
                default: state_q <= RUN;
            endcase
        end
    end

    assign bp.init_busy = (state_q == INIT);

    // Fetch-side lookup sees the table before any write landing this cycle
    always_comb begin
        bp.f_pred_taken  = 1'b0;
        bp.f_pred_target = '0;
        if (state_q == RUN) begin
            bp.f_pred_taken  = valid_q[fIdx] && (tag_q[fIdx] == fTag) && ctr_q[fIdx][1];
            bp.f_pred_target = target_q[fIdx];
        end
    end

    // RISC-V funct3 branch conditions; reserved encodings never take
    always_comb begin
        satisfied = 1'b0;
        case (bp.x_cond)
            3'b000:  satisfied = (bp.x_rs1 == bp.x_rs2);
            3'b001:  satisfied = (bp.x_rs1 != bp.x_rs2);
            3'b100:  satisfied = ($signed(bp.x_rs1) <  $signed(bp.x_rs2));
            3'b101:  satisfied = ($signed(bp.x_rs1) >= $signed(bp.x_rs2));
            3'b110:  satisfied = (bp.x_rs1 <  bp.x_rs2);
            3'b111:  satisfied = (bp.x_rs1 >= bp.x_rs2);
            default: satisfied = 1'b0;
        endcase
    end

    assign cf    = bp.x_valid & (bp.x_is_branch | bp.x_is_jump);
    assign taken = bp.x_is_jump | (bp.x_is_branch & satisfied);

    // Mispredict covers wrong direction, wrong target, and a non-branch that fetch jumped on
    always_comb begin
        mispredict = bp.x_valid & (
                        (cf & (taken != bp.x_pred_taken)) |
                        (cf & taken & bp.x_pred_taken & (bp.x_pred_target != bp.x_target)) |
                        (!cf & bp.x_pred_taken));
        bp.pc_load = mispredict;
        bp.flush   = mispredict;
        bp.pc_new  = '0;
        if (mispredict) begin
            bp.pc_new = taken ? bp.x_target : (bp.x_pc + XLEN'(4));
        end
    end

    // Table writes: clear sweep during INIT, otherwise train from the resolved instruction
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == INIT) begin
                valid_q[ptr_q] <= 1'b0;
                ctr_q[ptr_q]   <= 2'b01;
            end else if (cf && taken) begin
                valid_q[xIdx]  <= 1'b1;
                tag_q[xIdx]    <= xTag;
                target_q[xIdx] <= bp.x_target;
                if (xHit) begin
                    ctr_q[xIdx] <= (ctr_q[xIdx] == 2'b11) ? 2'b11 : ctr_q[xIdx] + 2'b01;
                end else begin
                    ctr_q[xIdx] <= 2'b10;
                end
            end else if (cf && !taken && xHit) begin
                ctr_q[xIdx] <= (ctr_q[xIdx] == 2'b00) ? 2'b00 : ctr_q[xIdx] - 2'b01;
            end else if (!cf && bp.x_valid && bp.x_pred_taken && xHit) begin
                valid_q[xIdx] <= 1'b0;
            end
        end
    end

`ifdef CORE_BRANCH_STATS_EN
    logic [31:0] statRes_q, statRes_d;
    logic [31:0] statMis_q, statMis_d;

    // Saturating event counts; they keep counting while the table is being cleared
    always_comb begin
        statRes_d = statRes_q;
        statMis_d = statMis_q;
        if (cf && (statRes_q != 32'hFFFF_FFFF)) begin
            statRes_d = statRes_q + 32'd1;
        end
        if (mispredict && (statMis_q != 32'hFFFF_FFFF)) begin
            statMis_d = statMis_q + 32'd1;
        end
    end

    // Statistics registers, cleared by rst
    always_ff @(posedge clk) begin
        if (rst) begin
            statRes_q <= '0;
            statMis_q <= '0;
        end else begin
            statRes_q <= statRes_d;
            statMis_q <= statMis_d;
        end
    end

    assign bp.stat_resolved   = statRes_q;
    assign bp.stat_mispredict = statMis_q;
`else
    assign bp.stat_resolved   = 32'd0;
    assign bp.stat_mispredict = 32'd0;
`endif
endmodule
